// File: rtl/home_actuator_driver.sv
// home_actuator_driver
// Checks that the FSM's one-hot request agrees with its state code and
// debounces it. Drives six actuator enables with a minimum on-time and an
// all-off gap between channels. Inconsistent inputs force everything off and
// bump a saturating fault counter.
module home_actuator_driver #(
  parameter int STABLE_CYC = 4,
  parameter int MIN_ON     = 16,
  parameter int GAP        = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] output_signals,
  input  logic [2:0] display,
  output logic [5:0] act_en,
  output logic [2:0] active_ch,
  output logic       busy,
  output logic       fault,
  output logic [7:0] fault_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_QUAL  = 3'd1;
  localparam logic [2:0] S_ON    = 3'd2;
  localparam logic [2:0] S_BREAK = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_STABLE = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] L_MIN_ON = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] L_GAP    = CNT_W'(GAP);

  logic [2:0]       r_state;
  logic [2:0]       r_cand;
  logic [CNT_W-1:0] r_stabCnt;
  logic [CNT_W-1:0] r_onCnt;
  logic [CNT_W-1:0] r_gapCnt;

  logic [2:0]       w_idx;
  logic             w_oneHot;
  logic             w_valid;
  logic [2:0]       w_code;
  logic [2:0]       w_stateNext;
  logic [2:0]       w_candNext;
  logic [CNT_W-1:0] w_stabNext;
  logic [CNT_W-1:0] w_onNext;
  logic [CNT_W-1:0] w_gapNext;
  logic [CNT_W-1:0] w_stabInc;
  logic [CNT_W-1:0] w_onInc;
  logic [CNT_W-1:0] w_gapInc;
  logic [5:0]       w_actNext;

  assign w_stabInc = r_stabCnt + L_ONE;
  assign w_onInc   = r_onCnt + L_ONE;
  assign w_gapInc  = r_gapCnt + L_ONE;

  // Decode the request into a channel code and decide whether it is consistent
  always_comb begin
    w_idx    = 3'd0;
    w_oneHot = 1'b1;
    case (output_signals)
      6'b000001: w_idx = 3'd1;
      6'b000010: w_idx = 3'd2;
      6'b000100: w_idx = 3'd3;
      6'b001000: w_idx = 3'd4;
      6'b010000: w_idx = 3'd5;
      6'b100000: w_idx = 3'd6;
      default:   w_oneHot = 1'b0;
    endcase
    if (output_signals == 6'd0) begin
      w_valid = (display == 3'd0) || (display == 3'd7);
    end else begin
      w_valid = w_oneHot && (display == w_idx);
    end
    w_code = w_valid ? w_idx : 3'd0;
  end

  // Next-state logic; an invalid sample overrides everything else, including timers
  always_comb begin
    w_stateNext = r_state;
    w_candNext  = r_cand;
    w_stabNext  = r_stabCnt;
    w_onNext    = r_onCnt;
    w_gapNext   = r_gapCnt;
    if (!w_valid) begin
      w_stateNext = S_FAULT;
      w_stabNext  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_code != 3'd0) begin
            w_candNext = w_code;
            if (L_STABLE <= L_ONE) begin
              w_stateNext = S_ON;
              w_onNext    = '0;
            end else begin
              w_stateNext = S_QUAL;
              w_stabNext  = L_ONE;
            end
          end
        end
        S_QUAL: begin
          if (w_code == 3'd0) begin
            w_stateNext = S_IDLE;
            w_stabNext  = '0;
          end else if (w_code == r_cand) begin
            if (w_stabInc >= L_STABLE) begin
              w_stateNext = S_ON;
              w_onNext    = '0;
            end else begin
              w_stabNext = w_stabInc;
            end
          end else begin
            w_candNext = w_code;
            w_stabNext = L_ONE;
          end
        end
        S_ON: begin
          if ((w_code != r_cand) && (w_onInc >= L_MIN_ON)) begin
            w_stateNext = S_BREAK;
            w_gapNext   = '0;
          end else if (w_onInc < L_MIN_ON) begin
            w_onNext = w_onInc;
          end
        end
        S_BREAK: begin
          // GAP samples are discarded; the following edge decides where to go
          if (r_gapCnt >= L_GAP) begin
            if (w_code == 3'd0) begin
              w_stateNext = S_IDLE;
            end else begin
              w_candNext = w_code;
              if (L_STABLE <= L_ONE) begin
                w_stateNext = S_ON;
                w_onNext    = '0;
              end else begin
                w_stateNext = S_QUAL;
                w_stabNext  = L_ONE;
              end
            end
          end else begin
            w_gapNext = w_gapInc;
          end
        end
        S_FAULT: begin
          if (w_stabInc >= L_STABLE) begin
            w_stateNext = S_IDLE;
            w_stabNext  = '0;
          end else begin
            w_stabNext = w_stabInc;
          end
        end
        default: begin
          w_stateNext = S_IDLE;
          w_stabNext  = '0;
        end
      endcase
    end
  end

  // One-hot enable pattern for the channel that will be on after this edge
  always_comb begin
    w_actNext = 6'd0;
    if (w_stateNext == S_ON) begin
      case (w_candNext)
        3'd1:    w_actNext = 6'b000001;
        3'd2:    w_actNext = 6'b000010;
        3'd3:    w_actNext = 6'b000100;
        3'd4:    w_actNext = 6'b001000;
        3'd5:    w_actNext = 6'b010000;
        3'd6:    w_actNext = 6'b100000;
        default: w_actNext = 6'd0;
      endcase
    end
  end

  // State, counters and registered outputs; reset drops enables without a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cand      <= 3'd0;
      r_stabCnt   <= '0;
      r_onCnt     <= '0;
      r_gapCnt    <= '0;
      act_en      <= 6'd0;
      active_ch   <= 3'd0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      fault_count <= 8'd0;
    end else begin
      r_state   <= w_stateNext;
      r_cand    <= w_candNext;
      r_stabCnt <= w_stabNext;
      r_onCnt   <= w_onNext;
      r_gapCnt  <= w_gapNext;
      act_en    <= w_actNext;
      active_ch <= (w_stateNext == S_ON) ? w_candNext : 3'd0;
      busy      <= (w_stateNext != S_IDLE);
      fault     <= (w_stateNext == S_FAULT);
      if ((w_stateNext == S_FAULT) && (r_state != S_FAULT) && (fault_count != 8'hFF)) begin
        fault_count <= fault_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/home_actuator_driver.md
# home_actuator_driver

Downstream consumer of the home-automation FSM's registered `output_signals` and `display` buses. It validates that the one-hot request agrees with the state code and debounces it. It then drives six physical actuator enables with a minimum on-time and a break-before-make gap between channels. Invalid input combinations force all actuators off and raise a counted fault. The block sits between the FSM and the actuator pads in the same clock domain.

## Interface

Parameters:
- `STABLE_CYC`, default 4: consecutive identical samples required to accept a request or clear a fault; must be ≥1.
- `MIN_ON`, default 16: minimum cycles an enabled channel stays on; must be ≥1.
- `GAP`, default 2: all-off cycles between dropping one channel and qualifying the next; must be ≥1.
- `CNT_W`, default 8: width of the internal counters; must hold `max(STABLE_CYC, MIN_ON, GAP)`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `output_signals`, input, 6: one-hot request from the FSM; bit k-1 is channel k.
- `display`, input, 3: FSM state code; 1..6 corresponds to channel 1..6; 0 and 7 mean no channel.
- `act_en`, output, 6: registered actuator enables; at most one bit is high.
- `active_ch`, output, 3: registered code of the enabled channel (1..6), or 0.
- `busy`, output, 1: registered; high when the state is not IDLE.
- `fault`, output, 1: registered; high while in FAULT.
- `fault_count`, output, 8: registered count of FAULT entries; saturates at 255.

## Operation

- Request code, evaluated each edge:
  - `output_signals`=0 with `display` in {0,7} gives code 0, which is valid.
  - Exactly one bit k-1 set with `display`==k gives code k, which is valid.
  - Anything else is invalid: multiple bits set, a one-hot value with a mismatched `display`, or zero with `display` in 1..6.
- States are IDLE, QUAL, ON, BREAK and FAULT.
- Invalid code in any state: next state is FAULT. `act_en`/`active_ch` go to 0 on that edge, overriding the min-on time. `fault_count` increments on entry only, not while remaining in FAULT.
- IDLE:
  - Valid code c≠0: go to QUAL with candidate c and stability count 1.
  - If `STABLE_CYC`=1, go directly to ON instead.
- QUAL:
  - Code equals the candidate: increment the count. When the request has been sampled identical on `STABLE_CYC` consecutive edges, go to ON on that edge.
  - Code is a different nonzero value: restart with the new candidate and count 1.
  - Code 0: go to IDLE.
- ON:
  - `act_en` = one-hot of the candidate; `active_ch` = candidate.
  - The on-time counter counts from the entry edge.
  - Code differs from `active_ch` and on-time ≥ `MIN_ON`: go to BREAK and clear `act_en` on that edge.
  - Otherwise hold. A request that drops during min-on is honoured at the first edge where on-time reaches `MIN_ON`.
- BREAK:
  - All enables are 0 for exactly `GAP` cycles.
  - Samples taken during BREAK do not count toward qualification.
  - At the end of BREAK: valid nonzero code goes to QUAL with count 1; code 0 goes to IDLE.
- FAULT:
  - Exit to IDLE when the code is valid (any value, including 0) on `STABLE_CYC` consecutive edges.
  - Any invalid sample restarts that count.
  - `fault` deasserts on the exit edge.

## Timing

- Reset (`rst_n`=0, asynchronous): state IDLE; `act_en`=0, `active_ch`=0, `busy`=0, `fault`=0, `fault_count`=0; all counters cleared.
  - Reset mid-operation drops all enables immediately, without waiting for a clock edge.
- Enable latency: `act_en` rises on the `STABLE_CYC`-th consecutive edge that samples the same valid nonzero code.
- Minimum on-time: `act_en` stays high for at least `MIN_ON` cycles.
- Release latency: after on-time ≥ `MIN_ON`, `act_en` drops on the first edge that samples a differing code.
- Channel switch: earliest enable of a new channel is `GAP`+`STABLE_CYC` edges after the old channel drops.
- Fault response: enables are off on the same edge that samples the invalid code, with no min-on protection.
- Simultaneous invalid code and an expiring timer: FAULT wins.
- `fault_count` at 255 stays at 255.

## Test plan

All scenarios use `STABLE_CYC`=4, `MIN_ON`=16, `GAP`=2.

1. Drive `output_signals`=6'b000100, `display`=3 from edge 0 → `act_en`=6'b000100 and `active_ch`=3 from edge 3 (4th sample); `busy`=1 from edge 0.
2. Drive the same request for 3 edges, then 0/0 → `act_en` never asserts; state returns to IDLE and `busy`=0.
3. Enable channel 3 at edge t, drop the request to 0 at t+2 → `act_en` stays 6'b000100 through t+15, is 0 at t+16, BREAK lasts 2 cycles, then IDLE.
4. Switch the request from channel 3 to channel 6 (6'b100000, `display`=6) after min-on → channel 3 drops at edge t, all enables are 0 for 2 cycles, and `act_en`=6'b100000 at t+2+4.
5. Drive `output_signals`=6'b000101 while ON → `act_en`=0, `fault`=1 and `fault_count`=1 on that edge; then 4 edges of valid 0/0 → `fault`=0 and IDLE. Repeat 260 faults → `fault_count`=255.
6. Assert `rst_n`=0 mid-ON between clock edges → all outputs 0 immediately. Release reset with channel 2 requested → channel 2 enables after 4 edges.
